delay_tap_scheduler: RTL and testbench

Per-sample sequencer for the shared single-port delay-line RAM in the multi-effects FPGA. Once per 48 kHz frame it reads every enabled effect tap (digital delay, chorus 1–3) and returns the tap data to the effects datapath. It then writes the new sample and advances the write pointer with a fixed decimation. This replaces hard-coded per-counter RAM address sequencing with one arbiter that owns the RAM port.

---
 rtl/delay_tap_scheduler.sv | 167 ++++++++++++++++
 tb/tb_delay_tap_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_tap_scheduler.sv
// Per-frame arbiter for the shared single-port delay-line RAM.
// Each frame reads every enabled tap, then writes the new sample and steps wr_ptr.
module delay_tap_scheduler #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 11,
    parameter int NTAPS = 4,
    parameter logic [NTAPS*ADDR_W-1:0] TAP_OFF = {13'h400, 13'h300, 13'h200, 13'h001},
    parameter int DECIM = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       frame_start,
    input  logic [DATA_W-1:0]                          sample_in,
    input  logic [NTAPS-1:0]                           tap_en,
    input  logic                                       clear_overrun,
    output logic                                       mem_we,
    output logic [ADDR_W-1:0]                          mem_addr,
    output logic [DATA_W-1:0]                          mem_wdata,
    input  logic [DATA_W-1:0]                          mem_rdata,
    output logic                                       tap_valid,
    output logic [(NTAPS > 1 ? $clog2(NTAPS) : 1)-1:0] tap_idx,
    output logic [DATA_W-1:0]                          tap_data,
    output logic                                       busy,
    output logic                                       frame_done,
    output logic                                       overrun,
    output logic [ADDR_W-1:0]                          wr_ptr
);

    localparam int IDX_W = NTAPS > 1 ? $clog2(NTAPS) : 1;
    localparam int DCNT_W = DECIM > 1 ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} stateT;

    stateT              state;
    stateT              nextState;
    logic [IDX_W-1:0]   curIdx;
    logic [NTAPS-1:0]   enLatched;
    logic [DATA_W-1:0]  sampleLatched;
    logic [DCNT_W-1:0]  dcnt;
    logic [ADDR_W-1:0]  wrPtr;
    logic               overrunQ;
    logic               tapValidQ;
    logic [IDX_W-1:0]   tapIdxQ;

    logic               firstFound;
    logic [IDX_W-1:0]   firstIdx;
    logic               nextFound;
    logic [IDX_W-1:0]   nextIdx;
    logic               startAccept;
    logic [ADDR_W-1:0]  curOff;

    // Lowest enabled tap of the incoming mask, and next enabled tap above curIdx.
    always_comb begin
        firstFound = 1'b0;
        firstIdx   = '0;
        nextFound  = 1'b0;
        nextIdx    = '0;
        for (int i = NTAPS - 1; i >= 0; i--) begin
            if (tap_en[i]) begin
                firstFound = 1'b1;
                firstIdx   = IDX_W'(i);
            end
            if (enLatched[i] && (i > int'(curIdx))) begin
                nextFound = 1'b1;
                nextIdx   = IDX_W'(i);
            end
        end
    end

    assign startAccept = frame_start && ((state == StIdle) || (state == StDone));
    assign curOff      = TAP_OFF[int'(curIdx) * ADDR_W +: ADDR_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            StIdle, StDone: begin
                if (frame_start) begin
                    nextState = firstFound ? StRead : StWrite;
                end else begin
                    nextState = StIdle;
                end
            end
            StRead:  nextState = nextFound ? StRead : StWrite;
            StWrite: nextState = StDone;
            default: nextState = StIdle;
        endcase
    end

    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = wrPtr;
        mem_wdata  = '0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            StRead: begin
                mem_addr = wrPtr - curOff;
                busy     = 1'b1;
            end
            StWrite: begin
                mem_we    = 1'b1;
                mem_wdata = sampleLatched;
                busy      = 1'b1;
            end
            StDone:  frame_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curIdx        <= '0;
            enLatched     <= '0;
            sampleLatched <= '0;
            dcnt          <= '0;
            wrPtr         <= '0;
            overrunQ      <= 1'b0;
            tapValidQ     <= 1'b0;
            tapIdxQ       <= '0;
        end else begin
            if (startAccept) begin
                sampleLatched <= sample_in;
                enLatched     <= tap_en;
                curIdx        <= firstIdx;
            end else if ((state == StRead) && nextFound) begin
                curIdx <= nextIdx;
            end

            // RAM returns read data one cycle after the READ address.
            tapValidQ <= (state == StRead);
            if (state == StRead) begin
                tapIdxQ <= curIdx;
            end

            if (state == StWrite) begin
                if (dcnt == DCNT_W'(DECIM - 1)) begin
                    dcnt  <= '0;
                    wrPtr <= wrPtr + ADDR_W'(1);
                end else begin
                    dcnt <= dcnt + DCNT_W'(1);
                end
            end

            // A late frame_start outranks a simultaneous clear.
            if (frame_start && busy) begin
                overrunQ <= 1'b1;
            end else if (clear_overrun) begin
                overrunQ <= 1'b0;
            end
        end
    end

    assign tap_valid = tapValidQ;
    assign tap_idx   = tapIdxQ;
    assign tap_data  = tapValidQ ? mem_rdata : '0;
    assign overrun   = overrunQ;
    assign wr_ptr    = wrPtr;

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Bench for delay_tap_scheduler: table-driven frames, tap scoreboard, DECIM wrap,
// overrun and mid-frame reset sequences against a behavioural RAM.
module tb_delay_tap_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [10:0] sample_in = '0;
    logic [3:0]  tap_en = '0;
    logic        clear_overrun = 1'b0;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [10:0] mem_wdata;
    logic [10:0] mem_rdata;
    logic        tap_valid;
    logic [1:0]  tap_idx;
    logic [10:0] tap_data;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [12:0] wr_ptr;

    delay_tap_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .sample_in    (sample_in),
        .tap_en       (tap_en),
        .clear_overrun(clear_overrun),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .tap_valid    (tap_valid),
        .tap_idx      (tap_idx),
        .tap_data     (tap_data),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .wr_ptr       (wr_ptr)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] OFF [4] = '{13'h001, 13'h200, 13'h300, 13'h400};
    localparam int DECIM = 2;

    // Synchronous-read RAM with a bench preload port.
    logic [10:0] ram [8192] = '{default: 11'h000};
    logic        preWe = 1'b0;
    logic [12:0] preAddr = '0;
    logic [10:0] preData = '0;
    always @(posedge clk) begin
        if (preWe) ram[preAddr] <= preData;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference state: expected RAM contents, write pointer and decimation count.
    logic [10:0] shadow [8192] = '{default: 11'h000};
    logic [12:0] mPtr = '0;
    int          mDcnt = 0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  idx;
        logic [10:0] data;
    } tapT;
    tapT sbq[$];

    typedef struct {
        logic [3:0]  en;
        logic [10:0] smp;
        int          wrCyc;
        int          doneCyc;
    } vecT;
    vecT vecs [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        tapT e;
        if (!reset && tap_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tap_unexpected: got idx %0d expected no pulse", tap_idx);
            end else begin
                e = sbq.pop_front();
                check("tap_idx", 32'(tap_idx), 32'(e.idx));
                check("tap_data", 32'(tap_data), 32'(e.data));
            end
        end
    end

    task automatic modelWrite(input logic [10:0] smp);
        shadow[mPtr] = smp;
        if (mDcnt == DECIM - 1) begin
            mDcnt = 0;
            mPtr  = mPtr + 13'd1;
        end else begin
            mDcnt++;
        end
    endtask

    task automatic runFrame(input logic [3:0] en, input logic [10:0] smp, input int wrCyc,
                            input int doneCyc, input int intrCyc, input logic clrWithIntr);
        int          list[$];
        tapT         t;
        logic [12:0] a;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                list.push_back(i);
                a = mPtr - OFF[i];
                t.idx  = 2'(i);
                t.data = shadow[a];
                sbq.push_back(t);
            end
        end
        @(negedge clk);
        frame_start = 1'b1;
        tap_en      = en;
        sample_in   = smp;
        @(posedge clk);
        #1 frame_start = 1'b0;
        for (int c = 1; c <= doneCyc; c++) begin
            @(negedge clk);
            frame_start   = 1'b0;
            clear_overrun = 1'b0;
            check("busy", 32'(busy), 32'(c < doneCyc));
            check("frame_done", 32'(frame_done), 32'(c == doneCyc));
            check("tap_valid", 32'(tap_valid), 32'(c >= 2 && c <= wrCyc));
            if (c < wrCyc && (c - 1) < list.size()) begin
                a = mPtr - OFF[list[c-1]];
                check("rd_we", 32'(mem_we), 32'd0);
                check("rd_addr", 32'(mem_addr), 32'(a));
            end else if (c == wrCyc) begin
                check("wr_we", 32'(mem_we), 32'd1);
                check("wr_addr", 32'(mem_addr), 32'(mPtr));
                check("wr_data", 32'(mem_wdata), 32'(smp));
                modelWrite(smp);
            end else begin
                check("done_we", 32'(mem_we), 32'd0);
                check("done_wrptr", 32'(wr_ptr), 32'(mPtr));
            end
            if (c == intrCyc) begin
                frame_start   = 1'b1;
                clear_overrun = clrWithIntr;
            end
        end
        frame_start   = 1'b0;
        clear_overrun = 1'b0;
        check("sb_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{en: 4'b1111, smp: 11'h055, wrCyc: 5, doneCyc: 6};
        vecs[1] = '{en: 4'b0010, smp: 11'h123, wrCyc: 2, doneCyc: 3};
        vecs[2] = '{en: 4'b0101, smp: 11'h2AA, wrCyc: 3, doneCyc: 4};
        vecs[3] = '{en: 4'b0000, smp: 11'h7FF, wrCyc: 1, doneCyc: 2};
        vecs[4] = '{en: 4'b1000, smp: 11'h001, wrCyc: 2, doneCyc: 3};

        // Reset, with a preload of RAM[1E00] for the tap-1 read.
        preWe   = 1'b1;
        preAddr = 13'h1E00;
        preData = 11'h4A3;
        shadow[13'h1E00] = 11'h4A3;
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_tap_valid", 32'(tap_valid), 32'd0);
        check("rst_tap_idx", 32'(tap_idx), 32'd0);
        check("rst_tap_data", 32'(tap_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        repeat (2) @(negedge clk);
        preWe = 1'b0;
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            runFrame(vecs[v].en, vecs[v].smp, vecs[v].wrCyc, vecs[v].doneCyc, 0, 1'b0);
        end
        check("no_overrun", 32'(overrun), 32'd0);

        // Fast back-to-back empty frames up to wr_ptr=1FFF with dcnt=0.
        tap_en    = 4'b0000;
        sample_in = 11'h000;
        while (!(mPtr == 13'h1FFF && mDcnt == 0)) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            modelWrite(11'h000);
        end
        @(negedge clk);
        check("pre_decim_ptr", 32'(wr_ptr), 32'h1FFF);
        runFrame(4'b0000, 11'h011, 1, 2, 0, 1'b0);
        runFrame(4'b0000, 11'h022, 1, 2, 0, 1'b0);
        runFrame(4'b0000, 11'h033, 1, 2, 0, 1'b0);
        runFrame(4'b0000, 11'h044, 1, 2, 0, 1'b0);
        check("decim_end_ptr", 32'(wr_ptr), 32'h0001);
        runFrame(4'b0011, 11'h155, 3, 4, 0, 1'b0);

        // frame_start during READ; then set-wins against a simultaneous clear.
        runFrame(4'b1111, 11'h111, 5, 6, 2, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        runFrame(4'b1111, 11'h222, 5, 6, 3, 1'b1);
        check("overrun_set_wins", 32'(overrun), 32'd1);
        @(negedge clk);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Reset in READ with overrun pending: everything returns to zero, no write.
        @(negedge clk);
        frame_start = 1'b1;
        tap_en      = 4'b1111;
        sample_in   = 11'h3FF;
        @(posedge clk);
        #1 frame_start = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_tap_valid", 32'(tap_valid), 32'd0);
        check("mid_rst_tap_data", 32'(tap_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_wr_ptr", 32'(wr_ptr), 32'd0);
        @(negedge clk);
        check("rst_hold_we", 32'(mem_we), 32'd0);
        check("rst_hold_tap_valid", 32'(tap_valid), 32'd0);
        reset = 1'b0;
        mPtr  = '0;
        mDcnt = 0;
        @(negedge clk);
        check("post_rst_tap_valid", 32'(tap_valid), 32'd0);
        check("post_rst_we", 32'(mem_we), 32'd0);
        runFrame(4'b1111, 11'h3C3, 5, 6, 0, 1'b0);
        runFrame(4'b0110, 11'h0F0, 3, 4, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
